// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch port datapath: packet class enum,
// packet word width and target-mask classification.
package switch_pkg;

  typedef enum logic [1:0] {
    SINGLE    = 2'd0,
    MULTICAST = 2'd1,
    BROADCAST = 2'd2
  } ptype_e;

  // Upper bound on port count accepted by derive_ptype.
  localparam int MAX_PORTS = 32;

  // Packet word is {data, source, target}.
  function automatic int pkt_width(input int num_ports, input int payload_w);
    return payload_w + 2 * num_ports;
  endfunction

  function automatic ptype_e derive_ptype(input logic [MAX_PORTS-1:0] target,
                                          input int num_ports);
    int   ones;
    logic all_set;
    ones    = 0;
    all_set = 1'b1;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (i < num_ports) begin
        ones    = ones + int'(target[i]);
        all_set = all_set & target[i];
      end
    end
    if (ones == 1) return SINGLE;
    if (all_set)   return BROADCAST;
    return MULTICAST;
  endfunction

endpackage

// File: rtl/switch_sync_fifo.sv
// Synchronous FIFO with occupancy count. Pop on empty is ignored; push on full
// is taken only when a pop frees the slot on the same edge.
module switch_sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/switch_port_ingress.sv
// Ingress stage of one switch port: legality check, FIFO buffering, paced replay.
// Define SWITCH_INGRESS_LOOPBACK_FILTER_EN to strip the source bit from target.
module switch_port_ingress
  import switch_pkg::*;
#(
  parameter  int NUM_PORTS      = 4,
  parameter  int PAYLOAD_W      = 8,
  parameter  int DEPTH          = 4,
  parameter  int SUSPEND_MARGIN = 1,
  parameter  int GAP_CYCLES     = 2,
  localparam int W              = pkt_width(NUM_PORTS, PAYLOAD_W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_ip,
  input  logic [W-1:0] data_ip,
  output logic         suspend_ip,
  output logic         valid_op,
  output logic [W-1:0] data_op,
  output logic [1:0]   ptype_op,
  input  logic         suspend_op,
  output logic         drop_o,
  output logic [7:0]   err_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [CW-1:0] SUSP_TH  = CW'(DEPTH - SUSPEND_MARGIN);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                 state;
  logic [GW-1:0]          gap_cnt;
  logic [NUM_PORTS-1:0]   src, tgt, tgt_f;
  logic [W-1:0]           push_word, head;
  logic [CW-1:0]          count, count_nxt;
  logic [MAX_PORTS-1:0]   head_tgt;
  logic                   full, empty, bad, push, pop, drop, slot_open;

  assign tgt = data_ip[NUM_PORTS-1:0];
  assign src = data_ip[2*NUM_PORTS-1:NUM_PORTS];

`ifdef SWITCH_INGRESS_LOOPBACK_FILTER_EN
  assign tgt_f = tgt & ~src;
`else
  assign tgt_f = tgt;
`endif

  assign push_word = {data_ip[W-1:NUM_PORTS], tgt_f};
  assign bad       = (tgt_f == '0) || (src == '0) ||
                     ((src & (src - NUM_PORTS'(1))) != '0);

  // A launch may happen from IDLE or on the last GAP cycle; with no gap,
  // back-to-back launches out of SEND keep one packet per cycle.
  assign slot_open = (state == IDLE) || (state == GAP && gap_cnt == '0) ||
                     (state == SEND && GAP_CYCLES == 0);
  assign pop       = slot_open && !empty && !suspend_op;
  assign drop      = valid_ip && (bad || (full && !pop));
  assign push      = valid_ip && !drop;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    head_tgt              = '0;
    head_tgt[NUM_PORTS-1:0] = head[NUM_PORTS-1:0];
  end

  switch_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      valid_op <= 1'b0;
      data_op  <= '0;
      ptype_op <= 2'd0;
    end else begin
      valid_op <= pop;
      if (pop) begin
        data_op  <= head;
        ptype_op <= derive_ptype(head_tgt, NUM_PORTS);
        state    <= SEND;
      end else begin
        case (state)
          SEND: begin
            state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
            gap_cnt <= GAP_LAST;
          end
          GAP: begin
            if (gap_cnt == '0) state <= IDLE;
            else               gap_cnt <= gap_cnt - GW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_o     <= 1'b0;
      err_count  <= '0;
      suspend_ip <= 1'b0;
    end else begin
      drop_o     <= drop;
      suspend_ip <= (count_nxt >= SUSP_TH);
      if (drop && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_switch_port_ingress.sv
// Bench for switch_port_ingress: directed vector table, hand-written corner
// sequences and randomized traffic against a cycle-time reference model.
module tb_switch_port_ingress;
  import switch_pkg::*;

  localparam int NP = 4, PW = 8, DEPTH = 4, MARGIN = 1, GAP = 2;
  localparam int W  = PW + 2 * NP;

  logic         clk = 1'b0, reset = 1'b0, valid_ip = 1'b0, suspend_op = 1'b0;
  logic [W-1:0] data_ip = '0;
  logic         suspend_ip, valid_op, drop_o;
  logic [W-1:0] data_op;
  logic [1:0]   ptype_op;
  logic [7:0]   err_count;
  int           checks = 0, errors = 0;

  always #5 clk = ~clk;

  switch_port_ingress #(
    .NUM_PORTS(NP), .PAYLOAD_W(PW), .DEPTH(DEPTH),
    .SUSPEND_MARGIN(MARGIN), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .valid_ip(valid_ip), .data_ip(data_ip),
    .suspend_ip(suspend_ip), .valid_op(valid_op), .data_op(data_op),
    .ptype_op(ptype_op), .suspend_op(suspend_op), .drop_o(drop_o),
    .err_count(err_count)
  );

  // Reference model: a packet queue plus the cycle of the last output pulse.
  logic [W-1:0] mq[$];
  longint       cyc, last_valid;
  logic         m_valid, m_susp, m_drop;
  logic [W-1:0] m_data;
  logic [1:0]   m_ptype;
  int           m_err;

  function automatic logic [1:0] ref_ptype(input logic [NP-1:0] t);
    if ($countones(t) == 1) return 2'd0;
    if (t == {NP{1'b1}})    return 2'd2;
    return 2'd1;
  endfunction

  task automatic model_reset();
    mq.delete();
    cyc = 0; last_valid = -100;
    m_valid = 0; m_susp = 0; m_drop = 0; m_data = '0; m_ptype = 2'd0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [NP-1:0] s, t;
    logic          launch, bad, ovf;
    int            pre;
    pre    = mq.size();
    launch = (pre > 0) && !suspend_op && ((cyc - last_valid) >= GAP);
    m_valid = launch;
    if (launch) begin
      m_data     = mq.pop_front();
      m_ptype    = ref_ptype(m_data[NP-1:0]);
      last_valid = cyc + 1;
    end
    m_drop = 1'b0;
    if (valid_ip) begin
      s = data_ip[2*NP-1:NP];
      t = data_ip[NP-1:0];
`ifdef SWITCH_INGRESS_LOOPBACK_FILTER_EN
      t = t & ~s;
`endif
      bad = (t == '0) || ($countones(s) != 1);
      ovf = (pre == DEPTH) && !launch;
      if (bad || ovf) begin
        m_drop = 1'b1;
        if (m_err < 255) m_err++;
      end else mq.push_back({data_ip[W-1:NP], t});
    end
    m_susp = (mq.size() >= DEPTH - MARGIN);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_valid_op",   32'(valid_op),   32'(m_valid));
    chk("m_data_op",    32'(data_op),    32'(m_data));
    chk("m_ptype_op",   32'(ptype_op),   32'(m_ptype));
    chk("m_suspend_ip", 32'(suspend_ip), 32'(m_susp));
    chk("m_drop_o",     32'(drop_o),     32'(m_drop));
    chk("m_err_count",  32'(err_count),  32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic so);
    valid_ip = v; data_ip = d; suspend_op = so;
  endtask

  typedef struct {
    logic v; logic [W-1:0] d; logic so;
    logic ev; logic [W-1:0] ed; logic [1:0] ep; logic es; logic edr; logic [7:0] eerr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [W-1:0] d, input logic so, input logic ev,
                     input logic [W-1:0] ed, input logic [1:0] ep, input logic es,
                     input logic edr, input logic [7:0] eerr);
    vec_t r;
    r.v = v; r.d = d; r.so = so; r.ev = ev; r.ed = ed; r.ep = ep;
    r.es = es; r.edr = edr; r.eerr = eerr;
    tbl.push_back(r);
  endtask

  logic [W-1:0] got[$];
  logic [W-1:0] ovf_pkts[5];
  logic [W-1:0] d6, d9;
  logic [1:0]   p6, p9;
  int           n;

  initial begin
`ifdef SWITCH_INGRESS_LOOPBACK_FILTER_EN
    d6 = 16'h1112; p6 = 2'd0; d9 = 16'h221E; p9 = 2'd1;
`else
    d6 = 16'h1113; p6 = 2'd1; d9 = 16'h221F; p9 = 2'd2;
`endif
    // single-target latency, then MULTICAST / BROADCAST / zero-target drop
    add(1, 16'hA512, 0,  0, 16'h0000, 0, 0, 0, 0);
    add(0, 16'h0000, 0,  1, 16'hA512, 0, 0, 0, 0);
    repeat (3) add(0, 16'h0000, 0,  0, 16'hA512, 0, 0, 0, 0);
    add(1, 16'h1113, 0,  0, 16'hA512, 0, 0, 0, 0);
    add(1, 16'h221F, 0,  1, d6, p6, 0, 0, 0);
    add(1, 16'h3310, 0,  0, d6, p6, 0, 1, 1);
    add(0, 16'h0000, 0,  0, d6, p6, 0, 0, 1);
    add(0, 16'h0000, 0,  1, d9, p9, 0, 0, 1);
    repeat (3) add(0, 16'h0000, 0,  0, d9, p9, 0, 0, 1);
    // downstream stall fills to the suspend threshold, then paced drain
    add(1, 16'hB112, 1,  0, d9, p9, 0, 0, 1);
    add(1, 16'hB224, 1,  0, d9, p9, 0, 0, 1);
    add(1, 16'hB348, 1,  0, d9, p9, 1, 0, 1);
    add(0, 16'h0000, 1,  0, d9, p9, 1, 0, 1);
    add(0, 16'h0000, 0,  1, 16'hB112, 0, 0, 0, 1);
    repeat (2) add(0, 16'h0000, 0,  0, 16'hB112, 0, 0, 0, 1);
    add(0, 16'h0000, 0,  1, 16'hB224, 0, 0, 0, 1);
    repeat (2) add(0, 16'h0000, 0,  0, 16'hB224, 0, 0, 0, 1);
    add(0, 16'h0000, 0,  1, 16'hB348, 0, 0, 0, 1);
    repeat (3) add(0, 16'h0000, 0,  0, 16'hB348, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_valid_op",   32'(valid_op),   0);
    chk("rst_data_op",    32'(data_op),    0);
    chk("rst_ptype_op",   32'(ptype_op),   0);
    chk("rst_suspend_ip", 32'(suspend_ip), 0);
    chk("rst_drop_o",     32'(drop_o),     0);
    chk("rst_err_count",  32'(err_count),  0);
    reset = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].so);
      cycle();
      chk($sformatf("tbl%0d_valid", i), 32'(valid_op),   32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i),  32'(data_op),    32'(tbl[i].ed));
      chk($sformatf("tbl%0d_ptype", i), 32'(ptype_op),   32'(tbl[i].ep));
      chk($sformatf("tbl%0d_susp", i),  32'(suspend_ip), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_drop", i),  32'(drop_o),     32'(tbl[i].edr));
      chk($sformatf("tbl%0d_err", i),   32'(err_count),  32'(tbl[i].eerr));
    end

    // overflow: five strobes while stalled, the fifth must be dropped
    ovf_pkts = '{16'hC112, 16'hC224, 16'hC348, 16'hC481, 16'hC512};
    for (int i = 0; i < 5; i++) begin
      drive(1, ovf_pkts[i], 1);
      cycle();
    end
    chk("ovf_drop", 32'(drop_o), 1);
    chk("ovf_err",  32'(err_count), 2);
    drive(0, '0, 0);
    got.delete();
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (valid_op) got.push_back(data_op);
    end
    chk("ovf_out_count", 32'(got.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_out%0d", i), 32'(got.size() > i ? got[i] : '0), 32'(ovf_pkts[i]));

    // reset in the middle of a gap with packets still queued
    for (int i = 0; i < 4; i++) begin
      drive(1, ovf_pkts[i] ^ 16'h1F00, 1);
      cycle();
    end
    drive(0, '0, 0);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("arst_valid_op",   32'(valid_op),   0);
    chk("arst_suspend_ip", 32'(suspend_ip), 0);
    chk("arst_err_count",  32'(err_count),  0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (valid_op) n++;
    end
    chk("post_reset_pulses", 32'(n), 0);

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, (i % 2 == 0) ? 16'h7710 : 16'h7733, 0);
      cycle();
    end
    chk("err_saturate", 32'(err_count), 255);
    drive(0, '0, 0);
    repeat (4) cycle();

`ifdef SWITCH_INGRESS_LOOPBACK_FILTER_EN
    drive(1, 16'h5513, 0);
    cycle();
    drive(1, 16'h6611, 0);
    cycle();
    chk("lb_self_drop", 32'(drop_o),   1);
    chk("lb_valid",     32'(valid_op), 1);
    chk("lb_data",      32'(data_op),  32'h5512);
    chk("lb_ptype",     32'(ptype_op), 0);
    drive(0, '0, 0);
    repeat (4) cycle();
`endif

    // randomized traffic with mostly-respected backpressure
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic          v;
      logic [NP-1:0] s, t;
      logic [PW-1:0] pd;
      v  = ($urandom_range(0, 99) < 55) && (!suspend_ip || $urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 9) < 8) ? NP'(1 << $urandom_range(0, NP - 1)) : NP'($urandom);
      t  = ($urandom_range(0, 9) == 0) ? {NP{1'b1}} : NP'($urandom);
      pd = PW'($urandom);
      drive(v, {pd, s, t}, $urandom_range(0, 99) < 25);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
